// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch controller: run/pause/adjust FSM with BCD digits.
// The 1 Hz, 2 Hz and pause inputs are edge-detected in the clk_100MHz domain.
module stopwatch_ctrl #(
  parameter int MIN_WRAP = 59
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  input  logic       clk_adjust,
  input  logic       btn_pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink_min,
  output logic       blink_sec
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] MW_T = 4'(MIN_WRAP / 10);
  localparam logic [3:0] MW_O = 4'(MIN_WRAP % 10);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ret_paused;
  logic       w_ret_nxt;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_nxt;

  logic r_1hz_q1, r_1hz_q2;
  logic r_2hz_q1, r_2hz_q2;
  logic r_btn_q1, r_btn_q2;
  logic w_tick1, w_tick2, w_pause;

  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    if (s == 8'h59)            return 8'h00;
    else if (s[3:0] == 4'd9)   return {s[7:4] + 4'd1, 4'd0};
    else                       return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m == {MW_T, MW_O})     return 8'h00;
    else if (m[3:0] == 4'd9)   return {m[7:4] + 4'd1, 4'd0};
    else                       return {m[7:4], m[3:0] + 4'd1};
  endfunction

  assign w_tick1 = r_1hz_q1 & ~r_1hz_q2;
  assign w_tick2 = r_2hz_q1 & ~r_2hz_q2;
  assign w_pause = r_btn_q1 & ~r_btn_q2;

  // Edge detectors preload the live level in reset so a held input yields no edge.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_1hz_q1 <= clk_1Hz;
      r_1hz_q2 <= clk_1Hz;
      r_2hz_q1 <= clk_2Hz;
      r_2hz_q2 <= clk_2Hz;
      r_btn_q1 <= btn_pause;
      r_btn_q2 <= btn_pause;
    end else begin
      r_1hz_q1 <= clk_1Hz;
      r_1hz_q2 <= r_1hz_q1;
      r_2hz_q1 <= clk_2Hz;
      r_2hz_q2 <= r_2hz_q1;
      r_btn_q1 <= btn_pause;
      r_btn_q2 <= r_btn_q1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_ret_paused <= 1'b0;
      r_min        <= 8'h00;
      r_sec        <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_ret_paused <= w_ret_nxt;
      r_min        <= w_min_nxt;
      r_sec        <= w_sec_nxt;
    end
  end

  // adj takes priority over a pause edge; pause edges are ignored in ADJUST.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_paused;
    case (r_state)
      ST_RUN: begin
        if (adj) begin
          w_state_nxt = ST_ADJUST;
          w_ret_nxt   = 1'b0;
        end else if (w_pause) begin
          w_state_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (adj) begin
          w_state_nxt = ST_ADJUST;
          w_ret_nxt   = 1'b1;
        end else if (w_pause) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_ADJUST: begin
        if (!adj) w_state_nxt = r_ret_paused ? ST_PAUSED : ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Ticks follow the rule of the state they arrive in, even on a transition cycle.
  always_comb begin
    w_min_nxt = r_min;
    w_sec_nxt = r_sec;
    if (r_state == ST_RUN && w_tick1) begin
      w_sec_nxt = inc_sec(r_sec);
      if (r_sec == 8'h59) w_min_nxt = inc_min(r_min);
    end else if (r_state == ST_ADJUST && w_tick2) begin
      if (sel) w_sec_nxt = inc_sec(r_sec);
      else     w_min_nxt = inc_min(r_min);
    end
  end

  assign min_tens  = r_min[7:4];
  assign min_ones  = r_min[3:0];
  assign sec_tens  = r_sec[7:4];
  assign sec_ones  = r_sec[3:0];
  assign running   = (r_state == ST_RUN);
  assign blink_min = (r_state == ST_ADJUST) & ~sel & clk_adjust;
  assign blink_sec = (r_state == ST_ADJUST) & sel & clk_adjust;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed stimulus pushes expected
// outputs, a monitor pops and compares them on the falling clock edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       clk_2Hz = 1'b0;
  logic       clk_adjust = 1'b0;
  logic       btn_pause = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink_min, blink_sec;

  int tests_run = 0;
  int fails = 0;

  logic [18:0] exp_q[$];
  string       name_q[$];

  stopwatch_ctrl #(.MIN_WRAP(59)) dut (
    .clk_100MHz(clk),
    .rst       (rst),
    .clk_1Hz   (clk_1Hz),
    .clk_2Hz   (clk_2Hz),
    .clk_adjust(clk_adjust),
    .btn_pause (btn_pause),
    .adj       (adj),
    .sel       (sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .blink_min (blink_min),
    .blink_sec (blink_sec)
  );

  always #5 clk = ~clk;

  // Monitor: one queued expectation is checked per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      logic [18:0] a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {min_tens, min_ones, sec_tens, sec_ones, running, blink_min, blink_sec};
      tests_run++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got mmss=%h run=%b bm=%b bs=%b, expected mmss=%h run=%b bm=%b bs=%b",
                 n, a[18:3], a[2], a[1], a[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic chk(input string n, input int mm, input int ss,
                     input logic run, input logic bm, input logic bs);
    logic [3:0] mt, mo, st, so;
    mt = 4'(mm / 10);
    mo = 4'(mm % 10);
    st = 4'(ss / 10);
    so = 4'(ss % 10);
    exp_q.push_back({mt, mo, st, so, run, bm, bs});
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    clk_1Hz = 1'b1;
    wait_cyc(2);
    clk_1Hz = 1'b0;
    wait_cyc(2);
  endtask

  task automatic pulse2();
    clk_2Hz = 1'b1;
    wait_cyc(2);
    clk_2Hz = 1'b0;
    wait_cyc(2);
  endtask

  task automatic pulse_pause();
    btn_pause = 1'b1;
    wait_cyc(2);
    btn_pause = 1'b0;
    wait_cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    chk("reset_state", 0, 0, 1, 0, 0);

    // Run and wrap at 60 seconds
    for (int i = 0; i < 60; i++) begin
      pulse1();
      if (i == 9) chk("run_10s", 0, 10, 1, 0, 0);
    end
    chk("run_60s", 1, 0, 1, 0, 0);

    // Preload 59:59 in ADJUST, then roll over to 00:00
    adj = 1'b1; sel = 1'b0;
    wait_cyc(2);
    chk("adj_enter", 1, 0, 0, 0, 0);
    for (int i = 0; i < 58; i++) pulse2();
    clk_adjust = 1'b1;
    chk("adj_min59_blink", 59, 0, 0, 1, 0);
    sel = 1'b1;
    for (int i = 0; i < 59; i++) pulse2();
    chk("adj_sec59_blink", 59, 59, 0, 0, 1);
    clk_adjust = 1'b0;
    adj = 1'b0;
    wait_cyc(2);
    chk("adj_exit_run", 59, 59, 1, 0, 0);
    pulse1();
    chk("wrap_5959", 0, 0, 1, 0, 0);

    // Pause holds digits against 1 Hz and 2 Hz edges
    for (int i = 0; i < 5; i++) pulse1();
    chk("run_5s", 0, 5, 1, 0, 0);
    pulse_pause();
    chk("paused", 0, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse1();
    pulse2();
    clk_adjust = 1'b1;
    chk("paused_hold_noblink", 0, 5, 0, 0, 0);
    clk_adjust = 1'b0;
    pulse_pause();
    chk("resumed", 0, 5, 1, 0, 0);
    pulse1();
    chk("run_6s", 0, 6, 1, 0, 0);

    // Adjust with no carry between fields
    adj = 1'b1; sel = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 3; i++) pulse2();
    chk("adj_min3", 3, 6, 0, 0, 0);
    sel = 1'b1;
    for (int i = 0; i < 52; i++) pulse2();
    clk_adjust = 1'b1;
    chk("adj_sec58", 3, 58, 0, 0, 1);
    pulse2();
    pulse2();
    chk("adj_nocarry", 3, 0, 0, 0, 1);
    pulse1();
    pulse_pause();
    chk("adj_ignore_1hz_pause", 3, 0, 0, 0, 1);
    clk_adjust = 1'b0;
    adj = 1'b0;
    wait_cyc(2);
    chk("adj_ret_run", 3, 0, 1, 0, 0);

    // Return to PAUSED after adjusting from PAUSED
    pulse_pause();
    chk("paused2", 3, 0, 0, 0, 0);
    adj = 1'b1;
    wait_cyc(2);
    pulse_pause();
    adj = 1'b0;
    wait_cyc(2);
    chk("adj_ret_paused", 3, 0, 0, 0, 0);
    pulse_pause();
    chk("run_again", 3, 0, 1, 0, 0);

    // Coincident 1 Hz and pause edges; digits change two cycles after the rise
    @(posedge clk);
    #1;
    clk_1Hz = 1'b1;
    btn_pause = 1'b1;
    chk("lat_rise", 3, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("lat_edge_n", 3, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("lat_edge_n1", 3, 1, 0, 0, 0);
    clk_1Hz = 1'b0;
    btn_pause = 1'b0;
    wait_cyc(3);
    chk("sim_paused_hold", 3, 1, 0, 0, 0);
    pulse_pause();
    chk("sim_resume", 3, 1, 1, 0, 0);

    // Reset mid-adjust at 12:34 with clk_1Hz held high
    adj = 1'b1; sel = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 9; i++) pulse2();
    sel = 1'b1;
    for (int i = 0; i < 33; i++) pulse2();
    chk("adj_1234", 12, 34, 0, 0, 0);
    clk_1Hz = 1'b1;
    wait_cyc(3);
    chk("adj_1hz_ignored", 12, 34, 0, 0, 0);
    rst = 1'b1;
    adj = 1'b0;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_mid_adjust", 0, 0, 1, 0, 0);
    wait_cyc(3);
    chk("rst_no_count", 0, 0, 1, 0, 0);
    clk_1Hz = 1'b0;
    wait_cyc(2);
    pulse1();
    chk("post_rst_count", 0, 1, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
